// File: rtl/bit_stream_encoder_if.sv
// Packet request / serial output bundle for bit_stream_encoder.
// Carries pkt_sent as well when BSE_PKT_SENT_EN is defined.
interface bit_stream_encoder_if;
  logic        pkt_avail;
  logic [7:0]  pkt_pid;
  logic [6:0]  pkt_addr;
  logic [3:0]  pkt_endp;
  logic [63:0] pkt_data;
  logic        send_stall;
  logic        bit_out;
  logic        send_start;
  logic        send_last;
`ifdef BSE_PKT_SENT_EN
  logic        pkt_sent;

  modport slave (
    input  pkt_avail, pkt_pid, pkt_addr, pkt_endp, pkt_data, send_stall,
    output bit_out, send_start, send_last, pkt_sent
  );

  modport master (
    output pkt_avail, pkt_pid, pkt_addr, pkt_endp, pkt_data, send_stall,
    input  bit_out, send_start, send_last, pkt_sent
  );
`else
  modport slave (
    input  pkt_avail, pkt_pid, pkt_addr, pkt_endp, pkt_data, send_stall,
    output bit_out, send_start, send_last
  );

  modport master (
    output pkt_avail, pkt_pid, pkt_addr, pkt_endp, pkt_data, send_stall,
    input  bit_out, send_start, send_last
  );
`endif
endinterface

// File: rtl/bit_stream_encoder.sv
// USB-style packet serializer: SYNC, PID, token/data payload and CRC, one bit per un-stalled clock.
// Define BSE_PKT_SENT_EN to add the pkt_sent completion pulse.
module bit_stream_encoder (
  input  logic                clk,
  input  logic                rst_L,
  bit_stream_encoder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_ADDR, S_ENDP, S_CRC5, S_DATA, S_CRC16
  } state_t;

  localparam logic [4:0]  CRC5_POLY  = 5'h05;
  localparam logic [15:0] CRC16_POLY = 16'h8005;

  function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic b);
    logic [4:0] sh;
    sh = {crc[3:0], 1'b0};
    return (b ^ crc[4]) ? (sh ^ CRC5_POLY) : sh;
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic [15:0] sh;
    sh = {crc[14:0], 1'b0};
    return (b ^ crc[15]) ? (sh ^ CRC16_POLY) : sh;
  endfunction

  // State names the field that bit_out carries now; r_cnt is the bit index within it.
  state_t      r_state, w_next_state;
  logic [5:0]  r_cnt, w_next_cnt;
  logic        r_bit_out, r_send_start, r_send_last;
  logic        w_bit, w_start, w_last, w_accept;
  logic [4:0]  r_crc5, w_crc5_next;
  logic [15:0] r_crc16, w_crc16_next;
  logic [7:0]  r_pid;
  logic [6:0]  r_addr;
  logic [3:0]  r_endp;
  logic [63:0] r_data;

  // Next field position.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    w_next_cnt   = r_cnt + 6'd1;
    w_accept     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_next_cnt = '0;
        if (bus.pkt_avail) begin
          w_next_state = S_SYNC;
          w_accept     = 1'b1;
        end
      end
      S_SYNC: if (r_cnt == 6'd7) begin
        w_next_state = S_PID;
        w_next_cnt   = '0;
      end
      S_PID: if (r_cnt == 6'd7) begin
        w_next_cnt = '0;
        unique case (r_pid[1:0])
          2'b01:   w_next_state = S_ADDR;
          2'b11:   w_next_state = S_DATA;
          default: w_next_state = S_IDLE;
        endcase
      end
      S_ADDR: if (r_cnt == 6'd6) begin
        w_next_state = S_ENDP;
        w_next_cnt   = '0;
      end
      S_ENDP: if (r_cnt == 6'd3) begin
        w_next_state = S_CRC5;
        w_next_cnt   = '0;
      end
      S_CRC5: if (r_cnt == 6'd4) begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
      S_DATA: if (r_cnt == 6'd63) begin
        w_next_state = S_CRC16;
        w_next_cnt   = '0;
      end
      S_CRC16: if (r_cnt == 6'd15) begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
      default: begin
        w_next_state = S_IDLE;
        w_next_cnt   = '0;
      end
    endcase
  end

  // Bit and flags for the next position; CRCs absorb each payload bit as it is emitted.
  always_comb begin
    w_bit        = 1'b0;
    w_start      = 1'b0;
    w_last       = 1'b0;
    w_crc5_next  = r_crc5;
    w_crc16_next = r_crc16;
    unique case (w_next_state)
      S_SYNC: begin
        w_bit   = (w_next_cnt == 6'd7);
        w_start = (w_next_cnt == 6'd0);
      end
      S_PID: begin
        w_bit  = r_pid[w_next_cnt[2:0]];
        w_last = (w_next_cnt == 6'd7) && !r_pid[0];
      end
      S_ADDR: begin
        w_bit       = r_addr[w_next_cnt[2:0]];
        w_crc5_next = crc5_step(r_crc5, w_bit);
      end
      S_ENDP: begin
        w_bit       = r_endp[w_next_cnt[1:0]];
        w_crc5_next = crc5_step(r_crc5, w_bit);
      end
      S_CRC5: begin
        w_bit  = ~r_crc5[3'd4 - w_next_cnt[2:0]];
        w_last = (w_next_cnt == 6'd4);
      end
      S_DATA: begin
        w_bit        = r_data[w_next_cnt];
        w_crc16_next = crc16_step(r_crc16, w_bit);
      end
      S_CRC16: begin
        w_bit  = ~r_crc16[~w_next_cnt[3:0]];
        w_last = (w_next_cnt == 6'd15);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit_out    <= 1'b0;
      r_send_start <= 1'b0;
      r_send_last  <= 1'b0;
      r_crc5       <= '1;
      r_crc16      <= '1;
    end else if (!bus.send_stall) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_bit_out    <= w_bit;
      r_send_start <= w_start;
      r_send_last  <= w_last;
      r_crc5       <= w_accept ? '1 : w_crc5_next;
      r_crc16      <= w_accept ? '1 : w_crc16_next;
    end
  end

  // NOTE: packet field holding registers carry no reset; they are loaded before they are ever read.
  always_ff @(posedge clk) begin
    if (w_accept && !bus.send_stall) begin
      r_pid  <= bus.pkt_pid;
      r_addr <= bus.pkt_addr;
      r_endp <= bus.pkt_endp;
      r_data <= bus.pkt_data;
    end
  end

  assign bus.bit_out    = r_bit_out;
  assign bus.send_start = r_send_start;
  assign bus.send_last  = r_send_last;

`ifdef BSE_PKT_SENT_EN
  // Fires on the edge that retires the last bit, so it is one cycle wide even under stall.
  logic r_pkt_sent;

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) r_pkt_sent <= 1'b0;
    else        r_pkt_sent <= r_send_last && !bus.send_stall;
  end

  assign bus.pkt_sent = r_pkt_sent;
`endif

endmodule

// File: tb/tb_bit_stream_encoder.sv
// Self-checking bench for bit_stream_encoder: queue-based packet model, directed vectors, random traffic.
module tb_bit_stream_encoder;
  typedef bit bitq_t[$];

  logic clk;
  logic rst_L;

  bit_stream_encoder_if bus();

  bit_stream_encoder dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] m_crc5(input logic [4:0] c, input bit b);
    logic [4:0] n;
    n = c << 1;
    if (b ^ c[4]) n = n ^ 5'b00101;
    return n;
  endfunction

  function automatic logic [15:0] m_crc16(input logic [15:0] c, input bit b);
    logic [15:0] n;
    n = c << 1;
    if (b ^ c[15]) n = n ^ 16'h8005;
    return n;
  endfunction

  // Full packet as an ordered list of bits, straight from the packet format.
  function automatic bitq_t build(input logic [7:0] pid, input logic [6:0] addr,
                                  input logic [3:0] endp, input logic [63:0] data);
    bitq_t q;
    logic [4:0]  c5  = 5'h1F;
    logic [15:0] c16 = 16'hFFFF;
    for (int i = 0; i < 7; i++) q.push_back(1'b0);
    q.push_back(1'b1);
    for (int i = 0; i < 8; i++) q.push_back(pid[i]);
    if (pid[1:0] == 2'b01) begin
      for (int i = 0; i < 7; i++) begin q.push_back(addr[i]); c5 = m_crc5(c5, addr[i]); end
      for (int i = 0; i < 4; i++) begin q.push_back(endp[i]); c5 = m_crc5(c5, endp[i]); end
      for (int i = 4; i >= 0; i--) q.push_back(~c5[i]);
    end else if (pid[1:0] == 2'b11) begin
      for (int i = 0; i < 64; i++) begin q.push_back(data[i]); c16 = m_crc16(c16, data[i]); end
      for (int i = 15; i >= 0; i--) q.push_back(~c16[i]);
    end
    return q;
  endfunction

  function automatic logic [127:0] pack(input bitq_t q);
    logic [127:0] v = '0;
    foreach (q[i]) v = {v[126:0], q[i]};
    return v;
  endfunction

  // Reference model: which bit of which packet is on the wire right now.
  bitq_t m_q;
  int    m_pos  = 0;
  bit    m_busy = 1'b0;
  bit    m_sent = 1'b0;

  always @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      m_busy = 1'b0;
      m_pos  = 0;
      m_sent = 1'b0;
    end else begin
      m_sent = 1'b0;
      if (!bus.send_stall) begin
        if (m_busy) begin
          if (m_pos == m_q.size() - 1) begin
            m_busy = 1'b0;
            m_sent = 1'b1;
          end else begin
            m_pos++;
          end
        end else if (bus.pkt_avail) begin
          m_q    = build(bus.pkt_pid, bus.pkt_addr, bus.pkt_endp, bus.pkt_data);
          m_pos  = 0;
          m_busy = 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    bit eb, es, el;
    eb = m_busy ? m_q[m_pos] : 1'b0;
    es = m_busy && (m_pos == 0);
    el = m_busy && (m_pos == m_q.size() - 1);
    check("bit_out", bus.bit_out, eb);
    check("send_start", bus.send_start, es);
    check("send_last", bus.send_last, el);
`ifdef BSE_PKT_SENT_EN
    check("pkt_sent", bus.pkt_sent, m_sent);
`endif
  end

  // Independent capture of the DUT's serial stream, one entry per consumed bit.
  logic [127:0] cap;
  int cap_n = 0;
  bit cap_active = 1'b0;
  int cyc = 0, start_cyc = 0, last_cyc = 0;
  bit prev_start = 1'b0, prev_last = 1'b0;

  always @(negedge clk or negedge rst_L) begin
    if (!rst_L) begin
      cap_active = 1'b0;
      prev_start = 1'b0;
      prev_last  = 1'b0;
    end else begin
      cyc++;
      if (bus.send_start && !prev_start) start_cyc = cyc;
      if (bus.send_last && !prev_last)   last_cyc  = cyc;
      prev_start = bus.send_start;
      prev_last  = bus.send_last;
      if (!bus.send_stall) begin
        if (bus.send_start) begin
          cap        = '0;
          cap_n      = 0;
          cap_active = 1'b1;
        end
        if (cap_active) begin
          cap = {cap[126:0], bus.bit_out};
          cap_n++;
          if (bus.send_last) cap_active = 1'b0;
        end
      end
    end
  end

  bit stall_rand  = 1'b0;
  bit stall_force = 1'b0;

  always @(posedge clk) begin
    #2;
    bus.send_stall = stall_rand ? ($urandom_range(0, 4) == 0) : stall_force;
  end

  task automatic send_pkt(input logic [7:0] pid, input logic [6:0] a,
                          input logic [3:0] e, input logic [63:0] d);
    bus.pkt_pid   = pid;
    bus.pkt_addr  = a;
    bus.pkt_endp  = e;
    bus.pkt_data  = d;
    bus.pkt_avail = 1'b1;
    for (int i = 0; i < 50 && !m_busy; i++) begin
      @(posedge clk);
      #1;
    end
    bus.pkt_avail = 1'b0;
    check("accepted", m_busy, 1'b1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 600 && m_busy; i++) begin
      @(posedge clk);
      #1;
    end
    check("finished", m_busy, 1'b0);
  endtask

  initial begin
    logic [127:0] v;
    bus.pkt_avail  = 1'b0;
    bus.pkt_pid    = '0;
    bus.pkt_addr   = '0;
    bus.pkt_endp   = '0;
    bus.pkt_data   = '0;
    bus.send_stall = 1'b0;
    rst_L = 1'b1;
    #1 rst_L = 1'b0;
    #2;
    check("rst_bit_out", bus.bit_out, 1'b0);
    check("rst_send_start", bus.send_start, 1'b0);
    check("rst_send_last", bus.send_last, 1'b0);
`ifdef BSE_PKT_SENT_EN
    check("rst_pkt_sent", bus.pkt_sent, 1'b0);
`endif
    #19 rst_L = 1'b1;
    @(posedge clk);
    #1;

    // Pin the model itself to hand-derived vectors.
    check("model_token", pack(build(8'hE1, 7'd5, 4'd4, 64'd0)), 128'h0187A041);
    check("model_ack", pack(build(8'hD2, 7'd0, 4'd0, 64'd0)), 128'h014B);
    v = pack(build(8'hC3, 7'd0, 4'd0, 64'hCAFEBABEDEADBEEF));
    check("model_data80", v[95:16], 80'h01C3F77DB57B7D5D7F53);

    // OUT token.
    send_pkt(8'hE1, 7'd5, 4'd4, 64'd0);
    wait_done();
    check("token_len", cap_n, 32);
    check("token_bits", cap, 128'h0187A041);
    check("token_crc5", cap[4:0], 5'b00001);
    check("token_start_to_last", last_cyc - start_cyc, 31);

    // OUT token with a 5-cycle stall while bit 23 is on the wire.
    send_pkt(8'hE1, 7'd5, 4'd4, 64'd0);
    repeat (23) begin @(posedge clk); #1; end
    stall_force = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    stall_force = 1'b0;
    wait_done();
    check("stall_token_bits", cap, 128'h0187A041);
    check("stall_start_to_last", last_cyc - start_cyc, 36);

    // DATA0.
    send_pkt(8'hC3, 7'd0, 4'd0, 64'hCAFEBABEDEADBEEF);
    wait_done();
    check("data_len", cap_n, 96);
    check("data_first80", cap[95:16], 80'h01C3F77DB57B7D5D7F53);
    check("data_full", cap, pack(build(8'hC3, 7'd0, 4'd0, 64'hCAFEBABEDEADBEEF)));
    check("data_start_to_last", last_cyc - start_cyc, 95);

    // ACK.
    send_pkt(8'hD2, 7'd0, 4'd0, 64'd0);
    wait_done();
    check("ack_len", cap_n, 16);
    check("ack_bits", cap, 128'h014B);
    check("ack_start_to_last", last_cyc - start_cyc, 15);

    // Request pulsed mid-token must not disturb the packet in flight.
    send_pkt(8'hE1, 7'd5, 4'd4, 64'd0);
    repeat (10) begin @(posedge clk); #1; end
    bus.pkt_pid   = 8'hD2;
    bus.pkt_addr  = 7'h7F;
    bus.pkt_endp  = 4'hF;
    bus.pkt_avail = 1'b1;
    @(posedge clk);
    #1;
    bus.pkt_avail = 1'b0;
    wait_done();
    check("midreq_token_bits", cap, 128'h0187A041);
    repeat (3) begin @(posedge clk); #1; end
    check("midreq_stays_idle", m_busy, 1'b0);

    // Asynchronous reset in the middle of a DATA payload of all ones.
    send_pkt(8'hC3, 7'd0, 4'd0, 64'hFFFFFFFFFFFFFFFF);
    repeat (40) begin @(posedge clk); #1; end
    #2;
    check("pre_reset_bit", bus.bit_out, 1'b1);
    rst_L = 1'b0;
    #1;
    check("async_rst_bit_out", bus.bit_out, 1'b0);
    check("async_rst_send_start", bus.send_start, 1'b0);
    check("async_rst_send_last", bus.send_last, 1'b0);
    #10 rst_L = 1'b1;
    @(posedge clk);
    #1;
    send_pkt(8'hD2, 7'd0, 4'd0, 64'd0);
    wait_done();
    check("post_reset_ack_bits", cap, 128'h014B);

    // Random packets of every type under random back-pressure.
    stall_rand = 1'b1;
    for (int n = 0; n < 30; n++) begin
      logic [3:0] p;
      p = 4'($urandom);
      send_pkt({~p, p}, 7'($urandom), 4'($urandom), {32'($urandom), 32'($urandom)});
      wait_done();
      check("rand_len", cap_n, m_q.size());
      check("rand_bits", cap, pack(m_q));
      if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
    end
    stall_rand = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
